// File: rtl/module_rca_result_display.sv
// module_rca_result_display
//   Takes the ripple-carry adder result and shows it in decimal on a
//   4-digit multiplexed common-anode 7-segment display. The binary value is
//   converted to BCD with double-dabble, one bit per clock. The last
//   converted value is held in bcd_po, and the display scans it continuously
//   with leading zeros blanked.
//
// Ports
//   clk_pi     system clock
//   rst_n_pi   asynchronous active-low reset (assert async, release sync)
//   result_pi  binary value to convert (WIDTH bits)
//   valid_pi   sample strobe, accepted only while idle
//   busy_po    high while a conversion is running
//   done_po    one-cycle pulse when bcd_po updates
//   bcd_po     4 BCD nibbles, [3:0] = ones
//   an_po      active-low one-hot digit enable, an_po[0] = ones digit
//   seg_po     active-low segments {g,f,e,d,c,b,a}
module module_rca_result_display #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic             clk_pi,
  input  logic             rst_n_pi,
  input  logic [WIDTH-1:0] result_pi,
  input  logic             valid_pi,
  output logic             busy_po,
  output logic             done_po,
  output logic [15:0]      bcd_po,
  output logic [3:0]       an_po,
  output logic [6:0]       seg_po
);

  localparam int unsigned CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH);
  localparam int unsigned REF_W = $clog2(REFRESH_DIV);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t             state, state_nxt;
  logic [1:0]         rst_sync;
  logic               rst_n;
  logic [WIDTH-1:0]   shift_reg;
  logic [15:0]        scratch;
  logic [15:0]        scratch_adj;
  logic [16+WIDTH-1:0] shifted;
  logic [CNT_W-1:0]   bit_cnt;
  logic               last_bit;
  logic [REF_W-1:0]   refresh_cnt;
  logic [1:0]         digit_idx;
  logic [3:0]         nib;
  logic [3:0]         blank;
  logic [3:0]         an_nxt;
  logic [6:0]         seg_nxt;

  // Reset is asserted asynchronously and released on a clock edge.
  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) rst_sync <= '0;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // State register.
  always_ff @(posedge clk_pi or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_pi) state_nxt = CONVERT;
      CONVERT: if (last_bit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy_po = (state == CONVERT);
  end

  // Double-dabble step: add 3 to every nibble >= 5, then shift the whole
  // {scratch, shift_reg} chain left by one.
  always_comb begin
    scratch_adj = scratch;
    for (int unsigned i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    shifted = {scratch_adj, shift_reg} << 1;
  end

  always_ff @(posedge clk_pi or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      scratch   <= '0;
      bit_cnt   <= '0;
      bcd_po    <= '0;
      done_po   <= 1'b0;
    end else begin
      done_po <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_pi) begin
            shift_reg <= result_pi;
            scratch   <= '0;
            bit_cnt   <= '0;
          end
        end
        CONVERT: begin
          {scratch, shift_reg} <= shifted;
          bit_cnt              <= bit_cnt + CNT_W'(1);
          if (last_bit) begin
            bcd_po  <= shifted[16+WIDTH-1 -: 16];
            done_po <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Digit scan, free running regardless of conversion activity.
  always_ff @(posedge clk_pi or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == REF_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + REF_W'(1);
    end
  end

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // A digit is blank when it and every digit above it are zero.
  always_comb begin
    blank[3] = (bcd_po[15:12] == 4'd0);
    blank[2] = blank[3] && (bcd_po[11:8] == 4'd0);
    blank[1] = blank[2] && (bcd_po[7:4] == 4'd0);
    blank[0] = 1'b0;
    nib      = bcd_po[{digit_idx, 2'b00} +: 4];
    an_nxt   = ~(4'b0001 << digit_idx);
    seg_nxt  = blank[digit_idx] ? 7'b1111111 : encode(nib);
  end

  // Anode and segment registers load on the same edge so digit and
  // pattern always change together.
  always_ff @(posedge clk_pi or negedge rst_n) begin
    if (!rst_n) begin
      an_po  <= 4'b1110;
      seg_po <= 7'b1000000;
    end else begin
      an_po  <= an_nxt;
      seg_po <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_module_rca_result_display.sv
module tb_module_rca_result_display;

  localparam int unsigned WIDTH       = 8;
  localparam int unsigned REFRESH_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  result = '0;
  logic        valid = 1'b0;
  logic        busy_po, done_po;
  logic [15:0] bcd_po;
  logic [3:0]  an_po;
  logic [6:0]  seg_po;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int done_cnt = 0;
  int d0;
  logic [15:0] exp_q[$];
  logic [15:0] popped;
  logic [6:0]  seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  always #5 clk = ~clk;

  module_rca_result_display #(.WIDTH(WIDTH), .REFRESH_DIV(REFRESH_DIV)) dut (
    .clk_pi   (clk),
    .rst_n_pi (rst_n),
    .result_pi(result),
    .valid_pi (valid),
    .busy_po  (busy_po),
    .done_po  (done_po),
    .bcd_po   (bcd_po),
    .an_po    (an_po),
    .seg_po   (seg_po)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] b, input int k);
    logic [3:0] n;
    n = b[4*k +: 4];
    if (k > 0 && (b >> (4*k)) == 16'd0) return 7'b1111111;
    return seg_tab[n];
  endfunction

  // Scoreboard: each done pulse consumes the oldest expected result.
  always @(negedge clk) begin
    if (done_po) begin
      done_cnt++;
      if (exp_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
      else begin
        popped = exp_q.pop_front();
        check("bcd_on_done", bcd_po, popped);
      end
    end
  end

  task automatic start(input logic [7:0] v, input bit accept);
    @(negedge clk);
    result = v;
    valid  = 1'b1;
    if (accept) exp_q.push_back(to_bcd(int'(v)));
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Entered at the first negedge after the capture edge.
  task automatic wait_done(input string tag);
    int busy_cyc = 0;
    int n = 0;
    while (!done_po && n < 40) begin
      if (busy_po) busy_cyc++;
      n++;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(done_po), 32'd1);
    check({tag, "_busy_cycles"}, busy_cyc, 32'd8);
    check({tag, "_busy_at_done"}, 32'(busy_po), 32'd0);
  endtask

  task automatic check_display(input logic [15:0] b, input string tag);
    logic [3:0] a_exp;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      a_exp = ~(4'b0001 << k);
      while (an_po !== a_exp && n < 40) begin
        n++;
        @(negedge clk);
      end
      check($sformatf("%s_an%0d", tag, k), 32'(an_po), 32'(a_exp));
      check($sformatf("%s_seg%0d", tag, k), 32'(seg_po), 32'(exp_seg(b, k)));
    end
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    check("rst_hold_bcd", bcd_po, 16'h0000);
    check("rst_hold_an", 32'(an_po), 32'b1110);
    check("rst_hold_seg", 32'(seg_po), 32'b1000000);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_bcd", bcd_po, 16'h0000);
    check("rst_an", 32'(an_po), 32'b1110);
    check("rst_seg", 32'(seg_po), 32'b1000000);
    check("rst_busy", 32'(busy_po), 32'd0);
    check("rst_done", 32'(done_po), 32'd0);
    repeat (3) @(negedge clk);

    // Max operand
    start(8'hFF, 1'b1);
    wait_done("max");
    check_display(16'h0255, "max");

    // Zero and blanking
    start(8'h00, 1'b1);
    wait_done("zero");
    check_display(16'h0000, "zero");
    start(8'd7, 1'b1);
    wait_done("seven");
    check_display(16'h0007, "seven");

    // valid during CONVERT is ignored
    d0 = done_cnt;
    start(8'd200, 1'b1);
    @(negedge clk);
    result = 8'd9;
    valid  = 1'b1;
    @(negedge clk);
    valid  = 1'b0;
    repeat (15) @(negedge clk);
    check("ignore_done_count", done_cnt - d0, 32'd1);
    check("ignore_bcd", bcd_po, 16'h0200);

    // Back-to-back with valid held high
    @(negedge clk);
    result = 8'd99;
    valid  = 1'b1;
    exp_q.push_back(to_bcd(99));
    for (int n = 0; n < 40 && !done_po; n++) @(negedge clk);
    check("b2b_first_done", 32'(done_po), 32'd1);
    check("b2b_busy_at_done", 32'(busy_po), 32'd0);
    result = 8'd100;
    exp_q.push_back(to_bcd(100));
    @(negedge clk);
    valid = 1'b0;
    check("b2b_busy_after_done", 32'(busy_po), 32'd1);
    wait_done("b2b");
    check_display(16'h0100, "b2b");

    // Reset mid-conversion
    d0 = done_cnt;
    start(8'd128, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy_po), 32'd0);
    check("midrst_bcd", bcd_po, 16'h0000);
    check("midrst_an", 32'(an_po), 32'b1110);
    check("midrst_seg", 32'(seg_po), 32'b1000000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 32'd0);
    check("midrst_bcd_after", bcd_po, 16'h0000);
    start(8'd128, 1'b1);
    wait_done("after_rst");
    check_display(16'h0128, "after_rst");

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/module_rca_result_display.md
Name: module_rca_result_display

Overview:
- Downstream stage of the 8-bit ripple-carry adder. Consumes the adder's result_po bus and presents it in decimal on a 4-digit, common-anode, multiplexed 7-segment display.
- Converts binary to BCD sequentially using double-dabble, one bit per clock.
- Holds the last converted value and continuously scans the digits.
- Leading zeros are blanked.

Parameters:
- WIDTH, 8, width of the binary result input. Legal range 1..13, so that the maximum value 8191 fits in 4 BCD digits.
- REFRESH_DIV, 100000, clock cycles each digit stays lit. Legal minimum is 2.

Ports:
- clk_pi  input  1  system clock.
- rst_n_pi  input  1  asynchronous active-low reset.
- result_pi  input  WIDTH  binary value from the adder's result_po.
- valid_pi  input  1  sample strobe; one-cycle pulse or level.
- busy_po  output  1  high while a conversion is in progress.
- done_po  output  1  one-cycle pulse when bcd_po updates.
- bcd_po  output  16  converted value; 4 BCD nibbles, [3:0] = ones.
- an_po  output  4  digit enables, active-low, one-hot; an_po[0] = ones digit.
- seg_po  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (async assert, sync deassert on clk_pi) puts the block in this state:
  - state IDLE, busy_po=0, done_po=0, bcd_po=16'h0000.
  - Refresh counter=0, digit index=0.
  - an_po=4'b1110, seg_po=7'b1000000 (shows "0").
- Reset asserted mid-conversion aborts the conversion; no done_po is produced.
- FSM states are IDLE and CONVERT.
- IDLE:
  - valid_pi=1 at a clock edge captures result_pi into the shift register.
  - Scratch BCD is cleared, bit counter set to 0.
  - Next state CONVERT, busy_po=1.
- CONVERT:
  - Each edge first adds 3 to every scratch BCD nibble >= 5 (combinationally), then shifts {bcd_scratch, shift_reg} left by 1.
  - The bit counter increments on each such edge.
  - On the WIDTH-th shift edge: bcd_po loads the final scratch value, done_po=1 for that cycle only, busy_po=0, next state IDLE.
- Latency: WIDTH clock edges from the capture edge to the bcd_po update. For WIDTH=8 that is 8 cycles.
- valid_pi while in CONVERT is ignored; there is no queueing and the captured operand is unaffected.
- valid_pi in the cycle where done_po=1 is accepted, because the FSM is already IDLE. This gives back-to-back conversions with no bubble.
- Changes on result_pi after capture have no effect on the ongoing conversion.
- bcd_po holds its value between conversions. Display output derives only from bcd_po and never from scratch.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 continuously, independent of FSM state.
  - On wrap, the digit index advances 0→1→2→3→0.
  - an_po drives low only the bit selected by the digit index.
  - seg_po is registered, updated in the same cycle as an_po, so there is no glitch between digit and pattern.
- Segment encoding (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - A nibble >9 (impossible in normal operation) shows 0111111 ("-").
- Leading-zero blanking:
  - Digit k (k>0) is blanked if it and all digits above it are 0. A blanked digit shows seg_po=1111111; an_po still scans normally.
  - Digit 0 is never blanked.
- Arithmetic: the scratch register is 16 bits and the shift register WIDTH bits. No overflow is possible within the legal WIDTH range.

Test Plan:
- Reset, with REFRESH_DIV=4: hold rst_n_pi=0, then release → bcd_po=0000, an_po=1110, seg_po=1000000, busy_po=0. Assert rst_n_pi=0 asynchronously between edges → outputs return to reset values immediately.
- Max operand: result_pi=8'hFF, valid_pi pulse → busy_po=1 for 8 cycles; done_po pulses on the 8th edge; bcd_po=16'h0255. Over the scan, the digits show an[0]="5", an[1]="5", an[2]="2", an[3] blank (1111111).
- Zero and blanking: result_pi=8'h00 → bcd_po=0000; digit0 shows "0"; digits 1–3 blank. Then result_pi=8'd7 → bcd_po=0007; digits 1–3 blank.
- Busy ignore: start a conversion of 8'd200; at cycle 3 apply valid_pi with result_pi=8'd9 → bcd_po=0200 and exactly one done_po pulse.
- Back-to-back: valid_pi held high with 8'd99, then switched to 8'd100 coincident with done_po → bcd_po=0099, then 0100 exactly 8 cycles later; busy_po low for only the done cycle.
- Reset mid-conversion: start 8'd128; assert reset at cycle 4; release → bcd_po=0000, no done_po. A subsequent conversion of 8'd128 → 0128.
